wb_stage: RTL and testbench

- Final (write-back) pipeline stage. Consumes the memory stage's 130-bit bus, commits register-file writes and drives the debug trace.
- Hosts the local CP0 registers Status, Cause, EPC, BadVAddr, Count and Compare, and forwards accesses to all other CP0 registers to the TLB block.
- Detects exceptions, ERET and interrupts at commit and generates the pipeline-wide flush and redirect PC.

---
 rtl/wb_stage.sv | 218 +++++++++++++++++++++
 tb/tb_wb_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: register-file commit, local CP0 registers, exception/interrupt flush.
// Optional Count/Compare timer interrupt enabled by defining TIMER_INT_EN.
module wb_stage #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
  parameter int          COUNT_DIV  = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ms_to_ws_valid,
  input  logic [129:0] ms_to_ws_bus,
  output logic         ws_allowin,
  input  logic [5:0]   ext_int,
  output logic [3:0]   rf_we,
  output logic [4:0]   rf_waddr,
  output logic [31:0]  rf_wdata,
  output logic [9:0]   stall_ws_bus,
  output logic [32:0]  forward_ws_bus,
  output logic         flush,
  output logic [31:0]  flush_pc,
  output logic         ws_entryhi_hazard,
  output logic [2:0]   tlb_op,
  output logic         cp0_ext_wen,
  output logic [7:0]   cp0_ext_addr,
  output logic [31:0]  cp0_ext_wdata,
  input  logic [31:0]  cp0_ext_rdata,
  output logic [31:0]  debug_wb_pc,
  output logic [3:0]   debug_wb_rf_wen,
  output logic [4:0]   debug_wb_rf_wnum,
  output logic [31:0]  debug_wb_rf_wdata
);
  localparam logic [7:0] ADDR_BADVADDR = 8'h40;
  localparam logic [7:0] ADDR_COUNT    = 8'h48;
  localparam logic [7:0] ADDR_COMPARE  = 8'h58;
  localparam logic [7:0] ADDR_STATUS   = 8'h60;
  localparam logic [7:0] ADDR_CAUSE    = 8'h68;
  localparam logic [7:0] ADDR_EPC      = 8'h70;

  logic         ws_valid_r;
  logic [129:0] bus_r;
  logic         entryhi_wen_s, tlbr_s, tlbwi_s, tlbp_s, bd_s, exc_s, eret_s, cp0_wen_s, res_from_cp0_s;
  logic [31:0]  badvaddr_s, result_s, pc_s;
  logic [7:0]   exc_type_s, cp0_addr_s;
  logic [3:0]   gr_we_s;
  logic [4:0]   dest_s;

  assign {entryhi_wen_s, tlbr_s, tlbwi_s, tlbp_s, badvaddr_s, bd_s, exc_s, exc_type_s, eret_s,
          cp0_wen_s, res_from_cp0_s, cp0_addr_s, gr_we_s, dest_s, result_s, pc_s} = bus_r;

  logic [7:0]  status_im_r;
  logic        status_exl_r, status_ie_r;
  logic        cause_bd_r;
  logic [7:0]  cause_ip_r;
  logic [4:0]  cause_code_r;
  logic [31:0] epc_r, badvaddr_r;
  logic [31:0] count_s, compare_s;
  logic        ti_s;

  logic        int_take_s, eff_exc_s, eret_take_s, cp0_wr_s, badv_upd_s, is_local_s, flush_s;
  logic [4:0]  exc_code_s;
  logic [31:0] status_rd_s, cause_rd_s, cp0_rdata_s, rf_wdata_s;
  logic [3:0]  rf_we_s;

  assign int_take_s  = ws_valid_r && status_ie_r && !status_exl_r && |(cause_ip_r & status_im_r);
  assign eff_exc_s   = ws_valid_r && (exc_s || int_take_s);
  assign eret_take_s = ws_valid_r && eret_s && !eff_exc_s;
  assign cp0_wr_s    = cp0_wen_s && ws_valid_r && !eff_exc_s;
  assign flush_s     = eff_exc_s || eret_take_s;

  // Exception code selection; an interrupt outranks every bus exception
  always_comb begin
    exc_code_s = 5'd0;
    if (int_take_s)         exc_code_s = 5'd0;
    else if (exc_type_s[6]) exc_code_s = 5'd4;
    else if (exc_type_s[7]) exc_code_s = 5'd10;
    else if (exc_type_s[1]) exc_code_s = 5'd12;
    else if (exc_type_s[3]) exc_code_s = 5'd8;
    else if (exc_type_s[2]) exc_code_s = 5'd9;
    else if (exc_type_s[5]) exc_code_s = 5'd4;
    else if (exc_type_s[4]) exc_code_s = 5'd5;
    else                    exc_code_s = 5'd0;
  end

  assign badv_upd_s  = (exc_code_s == 5'd4) || (exc_code_s == 5'd5);
  assign status_rd_s = {9'd0, 1'b1, 6'd0, status_im_r, 6'd0, status_exl_r, status_ie_r};
  assign cause_rd_s  = {cause_bd_r, ti_s, 14'd0, cause_ip_r, 1'b0, cause_code_r, 2'd0};

  // CP0 read mux; anything not held locally comes from the TLB block
  always_comb begin
    cp0_rdata_s = cp0_ext_rdata;
    is_local_s  = 1'b1;
    case (cp0_addr_s)
      ADDR_BADVADDR: cp0_rdata_s = badvaddr_r;
      ADDR_COUNT:    cp0_rdata_s = count_s;
      ADDR_COMPARE:  cp0_rdata_s = compare_s;
      ADDR_STATUS:   cp0_rdata_s = status_rd_s;
      ADDR_CAUSE:    cp0_rdata_s = cause_rd_s;
      ADDR_EPC:      cp0_rdata_s = epc_r;
      default: begin
        cp0_rdata_s = cp0_ext_rdata;
        is_local_s  = 1'b0;
      end
    endcase
  end

  assign rf_wdata_s = res_from_cp0_s ? cp0_rdata_s : result_s;
  assign rf_we_s    = (ws_valid_r && !eff_exc_s) ? gr_we_s : 4'd0;

  // Pipeline latch from the memory stage; a flush discards the incoming instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid_r <= 1'b0;
      bus_r      <= 130'd0;
    end else begin
      ws_valid_r <= flush_s ? 1'b0 : ms_to_ws_valid;
      if (ms_to_ws_valid) bus_r <= ms_to_ws_bus;
    end
  end

  // Status/Cause/EPC/BadVAddr update: exception, then ERET, then mtc0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_im_r  <= 8'd0;
      status_exl_r <= 1'b0;
      status_ie_r  <= 1'b0;
      cause_bd_r   <= 1'b0;
      cause_ip_r   <= 8'd0;
      cause_code_r <= 5'd0;
      epc_r        <= 32'd0;
      badvaddr_r   <= 32'd0;
    end else begin
      cause_ip_r[7:2] <= {ext_int[5] | ti_s, ext_int[4:0]};
      if (eff_exc_s) begin
        status_exl_r <= 1'b1;
        cause_code_r <= exc_code_s;
        if (!status_exl_r) begin
          epc_r      <= bd_s ? (pc_s - 32'd4) : pc_s;
          cause_bd_r <= bd_s;
        end
        if (badv_upd_s) badvaddr_r <= badvaddr_s;
      end else if (eret_take_s) begin
        status_exl_r <= 1'b0;
      end else if (cp0_wr_s) begin
        case (cp0_addr_s)
          ADDR_STATUS: begin
            status_im_r  <= result_s[15:8];
            status_exl_r <= result_s[1];
            status_ie_r  <= result_s[0];
          end
          ADDR_CAUSE: cause_ip_r[1:0] <= result_s[9:8];
          ADDR_EPC:   epc_r <= result_s;
          default:    epc_r <= epc_r;
        endcase
      end
    end
  end

`ifdef TIMER_INT_EN
  logic        tick_r, ti_r, count_inc_s, wr_count_s, wr_compare_s;
  logic [31:0] count_r, compare_r, count_nxt_s;

  assign wr_count_s   = cp0_wr_s && (cp0_addr_s == ADDR_COUNT);
  assign wr_compare_s = cp0_wr_s && (cp0_addr_s == ADDR_COMPARE);
  assign count_inc_s  = (COUNT_DIV == 1) ? 1'b1 : tick_r;

  // Next Count value: software write beats the divided increment
  always_comb begin
    count_nxt_s = count_r;
    if (wr_count_s)       count_nxt_s = result_s;
    else if (count_inc_s) count_nxt_s = count_r + 32'd1;
    else                  count_nxt_s = count_r;
  end

  // Count/Compare/TI state; a Compare write clears TI even on a match
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_r    <= 1'b0;
      count_r   <= 32'd0;
      compare_r <= 32'd0;
      ti_r      <= 1'b0;
    end else begin
      tick_r  <= wr_count_s ? 1'b0 : ~tick_r;
      count_r <= count_nxt_s;
      if (wr_compare_s) begin
        compare_r <= result_s;
        ti_r      <= 1'b0;
      end else if (count_nxt_s == compare_r) begin
        ti_r <= 1'b1;
      end
    end
  end

  assign count_s   = count_r;
  assign compare_s = compare_r;
  assign ti_s      = ti_r;
`else
  assign count_s   = 32'd0;
  assign compare_s = 32'd0;
  assign ti_s      = 1'b0;
`endif

  assign ws_allowin        = 1'b1;
  assign rf_we             = rf_we_s;
  assign rf_waddr          = dest_s;
  assign rf_wdata          = rf_wdata_s;
  assign stall_ws_bus      = {ws_valid_r && |gr_we_s, {4{ws_valid_r}} & gr_we_s, dest_s};
  assign forward_ws_bus    = {ws_valid_r && |gr_we_s, rf_wdata_s};
  assign flush             = flush_s;
  assign flush_pc          = eff_exc_s ? EXC_VECTOR : (eret_take_s ? epc_r : 32'd0);
  assign ws_entryhi_hazard = ws_valid_r && entryhi_wen_s;
  assign tlb_op            = (ws_valid_r && !eff_exc_s) ? {tlbr_s, tlbwi_s, tlbp_s} : 3'd0;
  assign cp0_ext_wen       = cp0_wr_s && !is_local_s;
  assign cp0_ext_addr      = cp0_addr_s;
  assign cp0_ext_wdata     = result_s;
  assign debug_wb_pc       = pc_s;
  assign debug_wb_rf_wen   = rf_we_s;
  assign debug_wb_rf_wnum  = dest_s;
  assign debug_wb_rf_wdata = rf_wdata_s;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: instructions are driven from the memory-stage side and the
// expected commit of each one is queued, then popped and compared one cycle later.
module tb_wb_stage;
  logic         clk = 1'b0;
  logic         reset, ms_to_ws_valid, ws_allowin, flush, ws_entryhi_hazard, cp0_ext_wen;
  logic [129:0] ms_to_ws_bus;
  logic [5:0]   ext_int;
  logic [3:0]   rf_we, debug_wb_rf_wen;
  logic [4:0]   rf_waddr, debug_wb_rf_wnum;
  logic [31:0]  rf_wdata, flush_pc, cp0_ext_wdata, cp0_ext_rdata, debug_wb_pc, debug_wb_rf_wdata;
  logic [9:0]   stall_ws_bus;
  logic [32:0]  forward_ws_bus;
  logic [2:0]   tlb_op;
  logic [7:0]   cp0_ext_addr;

  wb_stage dut (
    .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ms_to_ws_bus(ms_to_ws_bus),
    .ws_allowin(ws_allowin), .ext_int(ext_int), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .stall_ws_bus(stall_ws_bus), .forward_ws_bus(forward_ws_bus),
    .flush(flush), .flush_pc(flush_pc), .ws_entryhi_hazard(ws_entryhi_hazard), .tlb_op(tlb_op),
    .cp0_ext_wen(cp0_ext_wen), .cp0_ext_addr(cp0_ext_addr), .cp0_ext_wdata(cp0_ext_wdata),
    .cp0_ext_rdata(cp0_ext_rdata), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic [2:0]  tlb_op;
    logic        hazard;
    logic        ext_wen;
    logic [7:0]  ext_addr;
    logic [31:0] ext_wdata;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  localparam logic [31:0] VEC = 32'hBFC0_0380;

  task automatic chk(input string grp, input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", grp, name, obs, exp);
    end
  endtask

  function automatic logic [129:0] mk(input logic [31:0] pc, input logic [31:0] res, input logic [4:0] dest,
                                      input logic [3:0] gwe, input logic [7:0] caddr, input logic rfc,
                                      input logic cwen, input logic eret, input logic exc,
                                      input logic [7:0] et, input logic bd, input logic [31:0] bva);
    logic [129:0] b;
    b = '0;
    b[125:94] = bva; b[93] = bd; b[92] = exc; b[91:84] = et; b[83] = eret; b[82] = cwen;
    b[81] = rfc; b[80:73] = caddr; b[72:69] = gwe; b[68:64] = dest; b[63:32] = res; b[31:0] = pc;
    return b;
  endfunction

  function automatic logic [129:0] alu(input logic [31:0] pc, input logic [4:0] d, input logic [31:0] r);
    return mk(pc, r, d, 4'hF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0);
  endfunction
  function automatic logic [129:0] mtc0(input logic [31:0] pc, input logic [7:0] a, input logic [31:0] v);
    return mk(pc, v, 5'd0, 4'h0, a, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0);
  endfunction
  function automatic logic [129:0] mfc0(input logic [31:0] pc, input logic [7:0] a, input logic [4:0] d);
    return mk(pc, 32'd0, d, 4'hF, a, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 32'd0);
  endfunction
  function automatic logic [129:0] excb(input logic [31:0] pc, input logic [7:0] et, input logic bd, input logic [31:0] bva);
    return mk(pc, 32'd0, 5'd0, 4'hF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, et, bd, bva);
  endfunction

  function automatic exp_t e_ok(input string t, input logic [31:0] pc, input logic [3:0] we, input logic [4:0] wa, input logic [31:0] wd);
    exp_t e;
    e.tag = t; e.pc = pc; e.we = we; e.waddr = wa; e.wdata = wd; e.flush = 1'b0; e.flush_pc = 32'd0;
    e.tlb_op = 3'd0; e.hazard = 1'b0; e.ext_wen = 1'b0; e.ext_addr = 8'd0; e.ext_wdata = 32'd0;
    return e;
  endfunction
  function automatic exp_t e_fl(input string t, input logic [31:0] pc, input logic [31:0] fpc);
    exp_t e;
    e = e_ok(t, pc, 4'h0, 5'd0, 32'd0);
    e.flush = 1'b1; e.flush_pc = fpc;
    return e;
  endfunction

  task automatic check_pop();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard underflow observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, "pc", debug_wb_pc, e.pc);
      chk(e.tag, "rf_we", {28'd0, rf_we}, {28'd0, e.we});
      chk(e.tag, "dbg_wen", {28'd0, debug_wb_rf_wen}, {28'd0, e.we});
      if (e.we != 4'h0) begin
        chk(e.tag, "waddr", {27'd0, rf_waddr}, {27'd0, e.waddr});
        chk(e.tag, "wdata", rf_wdata, e.wdata);
        chk(e.tag, "dbg_wdata", debug_wb_rf_wdata, e.wdata);
      end
      chk(e.tag, "flush", {31'd0, flush}, {31'd0, e.flush});
      chk(e.tag, "flush_pc", flush_pc, e.flush_pc);
      chk(e.tag, "tlb_op", {29'd0, tlb_op}, {29'd0, e.tlb_op});
      chk(e.tag, "hazard", {31'd0, ws_entryhi_hazard}, {31'd0, e.hazard});
      chk(e.tag, "ext_wen", {31'd0, cp0_ext_wen}, {31'd0, e.ext_wen});
      if (e.ext_wen) begin
        chk(e.tag, "ext_addr", {24'd0, cp0_ext_addr}, {24'd0, e.ext_addr});
        chk(e.tag, "ext_wdata", cp0_ext_wdata, e.ext_wdata);
      end
    end
  endtask

  // Drive one instruction at a negedge, check its commit one cycle later, then leave a bubble.
  task automatic commit(input logic [129:0] b, input exp_t e);
    ms_to_ws_bus = b; ms_to_ws_valid = 1'b1; sb_q.push_back(e);
    @(negedge clk);
    ms_to_ws_valid = 1'b0;
    check_pop();
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    logic [129:0] b;
    reset = 1'b1; ms_to_ws_valid = 1'b0; ms_to_ws_bus = '0; ext_int = 6'd0; cp0_ext_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset", "ws_allowin", {31'd0, ws_allowin}, 32'd1);
    chk("reset", "rf_we", {28'd0, rf_we}, 32'd0);
    chk("reset", "flush", {31'd0, flush}, 32'd0);
    chk("reset", "flush_pc", flush_pc, 32'd0);
    chk("reset", "dbg_pc", debug_wb_pc, 32'd0);
    chk("reset", "stall", {22'd0, stall_ws_bus}, 32'd0);
    chk("reset", "fwd", forward_ws_bus[31:0], 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset asserted while an instruction sits in WB drops its write
    ms_to_ws_bus = alu(32'hBFC0_0010, 5'd4, 32'h55); ms_to_ws_valid = 1'b1;
    @(posedge clk); #2 reset = 1'b1; ms_to_ws_valid = 1'b0;
    #1;
    chk("rst_mid", "rf_we", {28'd0, rf_we}, 32'd0);
    chk("rst_mid", "dbg_pc", debug_wb_pc, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
`ifdef TIMER_INT_EN
    commit(mtc0(32'hBFC0_0014, 8'h58, 32'hFFFF_0000), e_ok("cmp_init", 32'hBFC0_0014, 4'h0, 5'd0, 32'd0));
`endif

    // ALU commit
    ms_to_ws_bus = alu(32'hBFC0_0000, 5'd5, 32'h1234); ms_to_ws_valid = 1'b1;
    sb_q.push_back(e_ok("alu", 32'hBFC0_0000, 4'hF, 5'd5, 32'h1234));
    @(negedge clk); ms_to_ws_valid = 1'b0;
    check_pop();
    chk("alu", "stall", {22'd0, stall_ws_bus}, 32'h3E5);
    chk("alu", "fwd_v", {31'd0, forward_ws_bus[32]}, 32'd1);
    chk("alu", "fwd_d", forward_ws_bus[31:0], 32'h1234);
    @(negedge clk);
    commit(alu(32'hBFC0_0004, 5'd31, 32'hA5A5_5A5A), e_ok("alu2", 32'hBFC0_0004, 4'hF, 5'd31, 32'hA5A5_5A5A));

    // Syscall in a delay slot
    commit(excb(32'hBFC0_0104, 8'h08, 1'b1, 32'd0), e_fl("sys", 32'hBFC0_0104, VEC));
    commit(mfc0(32'hBFC0_0380, 8'h70, 5'd2), e_ok("sys_epc", 32'hBFC0_0380, 4'hF, 5'd2, 32'hBFC0_0100));
    commit(mfc0(32'hBFC0_0384, 8'h68, 5'd2), e_ok("sys_cause", 32'hBFC0_0384, 4'hF, 5'd2, 32'h8000_0020));
    commit(mfc0(32'hBFC0_0388, 8'h60, 5'd2), e_ok("sys_status", 32'hBFC0_0388, 4'hF, 5'd2, 32'h0040_0002));

    // ERET to a software-written EPC
    commit(mtc0(32'hBFC0_038C, 8'h70, 32'hBFC0_0200), e_ok("epc_wr", 32'hBFC0_038C, 4'h0, 5'd0, 32'd0));
    commit(mk(32'hBFC0_0390, 32'd0, 5'd0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'd0),
           e_fl("eret", 32'hBFC0_0390, 32'hBFC0_0200));
    commit(mfc0(32'hBFC0_0200, 8'h60, 5'd3), e_ok("eret_status", 32'hBFC0_0200, 4'hF, 5'd3, 32'h0040_0000));

    // Data AdEL, then a lower-priority mix taken while EXL is already set
    commit(excb(32'hBFC0_0300, 8'h20, 1'b0, 32'h0000_0003), e_fl("adel", 32'hBFC0_0300, VEC));
    commit(mfc0(32'hBFC0_0380, 8'h40, 5'd6), e_ok("adel_bva", 32'hBFC0_0380, 4'hF, 5'd6, 32'h3));
    commit(mfc0(32'hBFC0_0384, 8'h68, 5'd6), e_ok("adel_cause", 32'hBFC0_0384, 4'hF, 5'd6, 32'h10));
    commit(excb(32'hBFC0_0388, 8'h86, 1'b1, 32'h0000_0077), e_fl("ri_prio", 32'hBFC0_0388, VEC));
    commit(mfc0(32'hBFC0_0380, 8'h68, 5'd6), e_ok("ri_cause", 32'hBFC0_0380, 4'hF, 5'd6, 32'h28));
    commit(mfc0(32'hBFC0_0384, 8'h70, 5'd6), e_ok("exl_epc", 32'hBFC0_0384, 4'hF, 5'd6, 32'hBFC0_0300));
    commit(mfc0(32'hBFC0_0388, 8'h40, 5'd6), e_ok("ri_bva", 32'hBFC0_0388, 4'hF, 5'd6, 32'h3));
    commit(mk(32'hBFC0_038C, 32'd0, 5'd0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 32'd0),
           e_fl("eret2", 32'hBFC0_038C, 32'hBFC0_0300));

    // External interrupt on IP2
    ext_int = 6'b000001;
    commit(mtc0(32'hBFC0_0300, 8'h60, 32'h0000_0401), e_ok("st_ie", 32'hBFC0_0300, 4'h0, 5'd0, 32'd0));
    commit(alu(32'hBFC0_0400, 5'd7, 32'h77), e_fl("int", 32'hBFC0_0400, VEC));
    ext_int = 6'd0;
    commit(mfc0(32'hBFC0_0380, 8'h68, 5'd8), e_ok("int_cause", 32'hBFC0_0380, 4'hF, 5'd8, 32'h0));
    commit(mfc0(32'hBFC0_0384, 8'h70, 5'd8), e_ok("int_epc", 32'hBFC0_0384, 4'hF, 5'd8, 32'hBFC0_0400));

    // Write masks on Cause and Status
    commit(mtc0(32'hBFC0_0388, 8'h68, 32'hFFFF_FFFF), e_ok("cause_wr", 32'hBFC0_0388, 4'h0, 5'd0, 32'd0));
    commit(mfc0(32'hBFC0_038C, 8'h68, 5'd8), e_ok("cause_mask", 32'hBFC0_038C, 4'hF, 5'd8, 32'h300));
    commit(mtc0(32'hBFC0_0390, 8'h60, 32'hFFFF_FFFF), e_ok("st_wr", 32'hBFC0_0390, 4'h0, 5'd0, 32'd0));
    commit(mfc0(32'hBFC0_0394, 8'h60, 5'd8), e_ok("st_mask", 32'hBFC0_0394, 4'hF, 5'd8, 32'h0040_FF03));
    commit(mtc0(32'hBFC0_0398, 8'h60, 32'h0), e_ok("st_clr", 32'hBFC0_0398, 4'h0, 5'd0, 32'd0));
    commit(mtc0(32'hBFC0_039C, 8'h68, 32'h0), e_ok("cause_clr", 32'hBFC0_039C, 4'h0, 5'd0, 32'd0));

    // Non-local CP0 access goes to the TLB block
    e = e_ok("ext_wr", 32'hBFC0_0500, 4'h0, 5'd0, 32'd0);
    e.ext_wen = 1'b1; e.ext_addr = 8'h50; e.ext_wdata = 32'hDEAD_BEEF;
    commit(mtc0(32'hBFC0_0500, 8'h50, 32'hDEAD_BEEF), e);
    cp0_ext_rdata = 32'hCAFE_F00D;
    commit(mfc0(32'hBFC0_0504, 8'h50, 5'd9), e_ok("ext_rd", 32'hBFC0_0504, 4'hF, 5'd9, 32'hCAFE_F00D));

    // TLB strobes, and their suppression under an exception
    b = alu(32'hBFC0_0508, 5'd0, 32'd0); b[126] = 1'b1; b[129] = 1'b1; b[72:69] = 4'h0;
    e = e_ok("tlbp", 32'hBFC0_0508, 4'h0, 5'd0, 32'd0); e.tlb_op = 3'b001; e.hazard = 1'b1;
    commit(b, e);
    b = excb(32'hBFC0_050C, 8'h08, 1'b0, 32'd0); b[127] = 1'b1;
    commit(b, e_fl("tlbwi_exc", 32'hBFC0_050C, VEC));

    // Flush kills the instruction arriving in the same cycle
    ms_to_ws_bus = excb(32'hBFC0_0600, 8'h04, 1'b0, 32'd0); ms_to_ws_valid = 1'b1;
    sb_q.push_back(e_fl("kill_bp", 32'hBFC0_0600, VEC));
    @(negedge clk);
    ms_to_ws_bus = alu(32'hBFC0_0604, 5'd9, 32'h99); ms_to_ws_valid = 1'b1;
    sb_q.push_back(e_ok("killed", 32'hBFC0_0604, 4'h0, 5'd9, 32'h99));
    check_pop();
    @(negedge clk); ms_to_ws_valid = 1'b0;
    check_pop();
    chk("killed", "stall_v", {31'd0, stall_ws_bus[9]}, 32'd0);
    @(negedge clk);
    commit(mtc0(32'hBFC0_0380, 8'h60, 32'h0), e_ok("st_clr2", 32'hBFC0_0380, 4'h0, 5'd0, 32'd0));

`ifdef TIMER_INT_EN
    commit(mtc0(32'hBFC0_0700, 8'h58, 32'd4), e_ok("cmp4", 32'hBFC0_0700, 4'h0, 5'd0, 32'd0));
    commit(mtc0(32'hBFC0_0704, 8'h48, 32'd0), e_ok("cnt0", 32'hBFC0_0704, 4'h0, 5'd0, 32'd0));
    commit(mtc0(32'hBFC0_0708, 8'h60, 32'h0040_8001), e_ok("st_tim", 32'hBFC0_0708, 4'h0, 5'd0, 32'd0));
    repeat (12) @(negedge clk);
    commit(alu(32'hBFC0_0710, 5'd10, 32'h10), e_fl("tim_int", 32'hBFC0_0710, VEC));
    commit(mfc0(32'hBFC0_0380, 8'h68, 5'd10), e_ok("tim_cause", 32'hBFC0_0380, 4'hF, 5'd10, 32'h4000_8000));
    commit(mfc0(32'hBFC0_0384, 8'h70, 5'd10), e_ok("tim_epc", 32'hBFC0_0384, 4'hF, 5'd10, 32'hBFC0_0710));
    commit(mtc0(32'hBFC0_0388, 8'h58, 32'h0000_1000), e_ok("cmp_clr", 32'hBFC0_0388, 4'h0, 5'd0, 32'd0));
    commit(mfc0(32'hBFC0_038C, 8'h68, 5'd10), e_ok("ti_clr", 32'hBFC0_038C, 4'hF, 5'd10, 32'h0));
`else
    commit(mtc0(32'hBFC0_0700, 8'h48, 32'd5), e_ok("cnt_wr", 32'hBFC0_0700, 4'h0, 5'd0, 32'd0));
    commit(mfc0(32'hBFC0_0704, 8'h48, 5'd10), e_ok("cnt_rd", 32'hBFC0_0704, 4'hF, 5'd10, 32'h0));
    commit(mfc0(32'hBFC0_0708, 8'h58, 5'd10), e_ok("cmp_rd", 32'hBFC0_0708, 4'hF, 5'd10, 32'h0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
